sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Shares one single-word SDRAM controller (sel/rd/wr/addr/din/bs -> dout/ready, refresh toggle) among
//  three requesters and a refresh scheduler. Sits directly in front of the controller.
//  Port 0 is video/sprite fetch, port 1 is CPU, port 2 is the loader.
//  Each requester uses a toggle req/ack handshake. The arbiter issues one access at a time,
//  tracks controller ready, and returns read data.
// PARAMETERS
//  REFRESH_CYCLES  780  clk cycles between refresh requests (64ms/8192 @100MHz)
//  RFSH_HOLD       8    cycles to wait after toggling mem_refresh; controller gives no ready for refresh
//  WATCHDOG        64   max cycles waiting for a ready edge before the access is abandoned
// PORTS
//  clk            in   1   system clock, same clock as the SDRAM controller
//  reset_n        in   1   asynchronous active-low reset
//  pN_req         in   1   N=0..2; toggle. Access is pending while pN_req != pN_ack
//  pN_we          in   1   1=write, 0=read; stable while pending
//  pN_addr        in   26  word address [26:1]; stable while pending
//  pN_din         in   16  write data; stable while pending
//  pN_bs          in   2   byte strobes {hi,lo} for writes
//  pN_ack         out  1   toggle; set equal to pN_req when the access completes
//  pN_dout        out  16  read data; valid from the cycle pN_ack toggles until the next read completes on that port
//  mem_sel        out  1   controller select
//  mem_rd/mem_wr  out  1   controller read/write request levels
//  mem_addr       out  26  to controller addr[26:1]
//  mem_din        out  16  to controller din
//  mem_bs         out  2   to controller bs
//  mem_dout       in   16  controller read data
//  mem_ready      in   1   controller ready: falls after command accept, rises at completion
//  mem_refresh    out  1   refresh toggle to controller
//  timeout        out  1   sticky; set when WATCHDOG expires, cleared only by reset
// BEHAVIOUR
//  Reset values: every output is 0, including all pN_ack, pN_dout and mem_refresh. State is IDLE,
//   refresh counter is 0, rfsh_pend is 0.
//  Refresh timer: increments every cycle. At REFRESH_CYCLES-1 it wraps to 0 and sets rfsh_pend.
//   A second expiry while rfsh_pend is set is not queued; rfsh_pend stays 1.
//  States: IDLE, ISSUE, BUSY, DONE, RFSH.
//  IDLE: grant priority is rfsh_pend > p0 > p1 > p2 (fixed).
//   - rfsh_pend granted: toggle mem_refresh, clear rfsh_pend, load hold counter with RFSH_HOLD-1, go RFSH.
//   - port granted: latch port index; drive mem_addr/din/bs from that port; mem_sel=1;
//     mem_rd=~we, mem_wr=we; go ISSUE.
//  ISSUE: hold mem_sel/rd/wr until mem_ready is sampled 0, then drop rd/wr/sel and go BUSY.
//  BUSY: wait for mem_ready=1. In that cycle capture mem_dout into pN_dout (reads only) and go DONE.
//  DONE: toggle pN_ack, then go IDLE. Access latency from IDLE grant to ack is >=4 cycles; a back-to-back
//   grant is possible the cycle after DONE.
//  RFSH: decrement the hold counter; go IDLE at 0. No port is granted during RFSH.
//  Watchdog: counts cycles in ISSUE+BUSY. At WATCHDOG it sets timeout, drops mem_rd/wr/sel, toggles
//   pN_ack (dout unchanged) and goes IDLE. The requester is never left hung.
//  A pending access is never pre-empted. Refresh becoming due during an access is served at the next IDLE.
//  A port toggling req again while its own access is in flight is ignored until DONE.
//   After DONE, req != ack again, so that is a new access.
//  Asynchronous reset mid-access: all outputs return to 0 immediately and pending requests are dropped.
//   Requesters are reset by the same reset_n.
//  mem_addr/din/bs hold their last value when not selected. No combinational path from pN_* to mem_*.
// TESTING
//  1. Single p1 read: addr 26'h0001234, controller model returns 16'hBEEF
//     -> mem_rd pulse seen, p1_dout=BEEF, p1_ack toggles once.
//  2. p0, p1, p2 toggle req in the same cycle -> grants in order 0,1,2; three acks; no overlap of mem_sel
//     between grants.
//  3. Write p2 we=1 bs=2'b01 din=16'h00A5 -> mem_wr=1, mem_bs=01, mem_din=00A5; p2_dout unchanged.
//  4. Refresh becomes due while a p1 access is in BUSY -> p1 completes first, then mem_refresh toggles,
//     then 8 idle cycles follow before a pending p0 is granted.
//  5. Controller model never lowers ready -> after 64 cycles timeout=1, port ack toggles, next request
//     is still served.
//  6. reset_n low during BUSY -> all outputs 0 asynchronously; after release the refresh counter restarts
//     at 0 and first mem_refresh toggles at cycle 780.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares one single-word SDRAM controller among three toggle-handshake requesters
// and a periodic refresh scheduler. Only one access is ever in flight.
module sdram_arbiter #(
   parameter int REFRESH_CYCLES = 780,
   parameter int RFSH_HOLD      = 8,
   parameter int WATCHDOG       = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [25:0] p0_addr,
   input  logic [15:0] p0_din,
   input  logic [1:0]  p0_bs,
   output logic        p0_ack,
   output logic [15:0] p0_dout,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [25:0] p1_addr,
   input  logic [15:0] p1_din,
   input  logic [1:0]  p1_bs,
   output logic        p1_ack,
   output logic [15:0] p1_dout,
   input  logic        p2_req,
   input  logic        p2_we,
   input  logic [25:0] p2_addr,
   input  logic [15:0] p2_din,
   input  logic [1:0]  p2_bs,
   output logic        p2_ack,
   output logic [15:0] p2_dout,
   output logic        mem_sel,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [25:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_bs,
   input  logic [15:0] mem_dout,
   input  logic        mem_ready,
   output logic        mem_refresh,
   output logic        timeout
);
   localparam int RC_W   = $clog2(REFRESH_CYCLES);
   localparam int HOLD_W = $clog2(RFSH_HOLD + 1);
   localparam int WD_W   = $clog2(WATCHDOG + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, RFSH} state_t;
   state_t state, state_next;

   logic [RC_W-1:0]   rfsh_cnt;
   logic              rfsh_pend;
   logic              rfsh_wrap;
   logic [HOLD_W-1:0] hold_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              wd_expired;
   logic [2:0]        req;
   logic [2:0]        ack;
   logic [2:0]        pend;
   logic [2:0]        gnt;
   logic [2:0]        cur_port;
   logic              cur_we;
   logic [15:0]       dout [3];
   logic              gnt_we;
   logic [25:0]       gnt_addr;
   logic [15:0]       gnt_din;
   logic [1:0]        gnt_bs;
   logic              start_rfsh;
   logic              start_access;
   logic              accepted;
   logic              completed;
   logic              finish;
   logic              abandon;

   assign req        = {p2_req, p1_req, p0_req};
   assign pend       = req ^ ack;
   assign p0_ack     = ack[0];
   assign p1_ack     = ack[1];
   assign p2_ack     = ack[2];
   assign p0_dout    = dout[0];
   assign p1_dout    = dout[1];
   assign p2_dout    = dout[2];
   assign rfsh_wrap  = (rfsh_cnt == RC_W'(REFRESH_CYCLES - 1));
   assign wd_expired = (wd_cnt == WD_W'(WATCHDOG - 1));

   // Fixed priority p0 > p1 > p2; the chosen port's command fields feed registers only.
   always_comb begin
      gnt      = 3'b000;
      gnt_we   = 1'b0;
      gnt_addr = '0;
      gnt_din  = '0;
      gnt_bs   = '0;
      if (pend[0]) begin
         gnt = 3'b001; gnt_we = p0_we; gnt_addr = p0_addr; gnt_din = p0_din; gnt_bs = p0_bs;
      end else if (pend[1]) begin
         gnt = 3'b010; gnt_we = p1_we; gnt_addr = p1_addr; gnt_din = p1_din; gnt_bs = p1_bs;
      end else if (pend[2]) begin
         gnt = 3'b100; gnt_we = p2_we; gnt_addr = p2_addr; gnt_din = p2_din; gnt_bs = p2_bs;
      end
   end

   always_comb begin
      state_next   = state;
      start_rfsh   = 1'b0;
      start_access = 1'b0;
      accepted     = 1'b0;
      completed    = 1'b0;
      finish       = 1'b0;
      abandon      = 1'b0;
      case (state)
         IDLE: begin
            if (rfsh_pend) begin
               start_rfsh = 1'b1;
               state_next = RFSH;
            end else if (gnt != 3'b000) begin
               start_access = 1'b1;
               state_next   = ISSUE;
            end
         end
         ISSUE: begin
            if (!mem_ready) begin
               accepted   = 1'b1;
               state_next = BUSY;
            end else if (wd_expired) begin
               abandon    = 1'b1;
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               completed  = 1'b1;
               state_next = DONE;
            end else if (wd_expired) begin
               abandon    = 1'b1;
               state_next = IDLE;
            end
         end
         DONE: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         RFSH: begin
            if (hold_cnt == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // A refresh that expires while one is already pending collapses into it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rfsh_cnt    <= '0;
         rfsh_pend   <= 1'b0;
         hold_cnt    <= '0;
         wd_cnt      <= '0;
         ack         <= 3'b000;
         cur_port    <= 3'b000;
         cur_we      <= 1'b0;
         mem_sel     <= 1'b0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= '0;
         mem_bs      <= '0;
         mem_refresh <= 1'b0;
         timeout     <= 1'b0;
         for (int i = 0; i < 3; i++) dout[i] <= '0;
      end else begin
         if (rfsh_wrap) rfsh_cnt <= '0;
         else           rfsh_cnt <= rfsh_cnt + RC_W'(1);

         if (rfsh_wrap)       rfsh_pend <= 1'b1;
         else if (start_rfsh) rfsh_pend <= 1'b0;

         if (start_rfsh) begin
            mem_refresh <= ~mem_refresh;
            hold_cnt    <= HOLD_W'(RFSH_HOLD - 1);
         end else if (state == RFSH && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end

         if (start_access) begin
            cur_port <= gnt;
            cur_we   <= gnt_we;
            mem_addr <= gnt_addr;
            mem_din  <= gnt_din;
            mem_bs   <= gnt_bs;
            mem_sel  <= 1'b1;
            mem_rd   <= ~gnt_we;
            mem_wr   <= gnt_we;
            wd_cnt   <= '0;
         end else if (state == ISSUE || state == BUSY) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end

         if (accepted || abandon) begin
            mem_sel <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
         end

         if (abandon) timeout <= 1'b1;

         if (completed && !cur_we) begin
            for (int i = 0; i < 3; i++) begin
               if (cur_port[i]) dout[i] <= mem_dout;
            end
         end

         if (finish || abandon) ack <= ack ^ cur_port;
      end
   end
endmodule
